ber_align_ctrl: RTL and testbench

Sequencer for the TX-filter BER checker. Sweeps the PRBS reference delay tap across all candidate positions and measures errors over a fixed window at each tap. Selects the tap with the fewest errors, then locks to it and runs continuous BER accumulation. Sits between the filter/PRBS datapath, which consumes o_delay and returns a per-bit error flag, and the status/LED logic.

---
 rtl/ber_align_ctrl_pkg.sv | 18 +
 rtl/ber_align_ctrl_sat_counter.sv | 27 ++
 rtl/ber_align_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ber_align_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_align_ctrl_pkg.sv
// Shared types and default constants for the BER alignment sequencer.
// The BER_EARLY_LOCK_EN build option is handled in ber_align_ctrl.
package ber_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_NEXT,
    ST_LOCKED
  } ber_state_e;

  localparam int PRBS9_PERIOD   = 511;
  localparam int DEF_NUM_DELAYS = 1024;
  localparam int DEF_WIN_LEN    = PRBS9_PERIOD;
  localparam int DEF_SETTLE     = 2;

endpackage

// File: rtl/ber_align_ctrl_sat_counter.sv
// Saturating up-counter with clock enable and synchronous clear.
module ber_sat_counter #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count_d = count_q + W'(1);
  assign o_count = count_q;

  always_ff @(posedge clock) begin
    if (i_reset || i_clear) begin
      count_q <= '0;
    end else if (i_en && i_inc && (count_q != '1)) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ber_align_ctrl.sv
// Delay-tap sweep, best-tap selection and locked BER accumulation.
// Build option BER_EARLY_LOCK_EN: lock on the first tap whose window is error-free.
module ber_align_ctrl
  import ber_pkg::*;
#(
  parameter int NUM_DELAYS = DEF_NUM_DELAYS,
  parameter int DELAY_W    = 10,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int ERR_THRESH = 0,
  parameter int CNT_W      = 64
) (
  input  logic                           clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_start,
  input  logic                           i_valid,
  input  logic                           i_err,
  output logic [DELAY_W-1:0]             o_delay,
  output logic                           o_busy,
  output logic                           o_locked,
  output logic                           o_fail,
  output logic [DELAY_W-1:0]             o_best_delay,
  output logic [$clog2(WIN_LEN+1)-1:0]   o_min_err,
  output logic [CNT_W-1:0]               o_bit_count,
  output logic [CNT_W-1:0]               o_err_count
);

  localparam int MIN_W = $clog2(WIN_LEN + 1);
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [DELAY_W-1:0] LAST_TAP = DELAY_W'(NUM_DELAYS - 1);

  ber_state_e         state_q;
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] best_q;
  logic [MIN_W-1:0]   min_err_q;
  logic [MIN_W-1:0]   win_cnt_q;
  logic [MIN_W-1:0]   err_sum_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic               busy_q;
  logic               locked_q;
  logic               fail_q;

  logic [MIN_W-1:0]   err_sum_d;
  logic [MIN_W-1:0]   win_cnt_d;
  logic               start_ok;
  logic               cnt_en;

  assign err_sum_d = err_sum_q + MIN_W'(i_err);
  assign win_cnt_d = win_cnt_q + MIN_W'(1);
  assign start_ok  = i_enable && i_start &&
                     ((state_q == ST_IDLE) || (state_q == ST_LOCKED));
  assign cnt_en    = i_enable && i_valid && (state_q == ST_LOCKED);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      delay_q      <= '0;
      best_q       <= '0;
      min_err_q    <= '1;
      win_cnt_q    <= '0;
      err_sum_q    <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else if (i_enable) begin
      case (state_q)
        ST_IDLE, ST_LOCKED: begin
          if (i_start) begin
            state_q      <= ST_SETTLE;
            delay_q      <= '0;
            best_q       <= '0;
            min_err_q    <= '1;
            settle_cnt_q <= '0;
            busy_q       <= 1'b1;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (SETTLE == 0) begin
            state_q   <= ST_MEASURE;
            win_cnt_q <= '0;
            err_sum_q <= '0;
          end else if (i_valid) begin
            if (int'(settle_cnt_q) == SETTLE - 1) begin
              state_q   <= ST_MEASURE;
              win_cnt_q <= '0;
              err_sum_q <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + SET_W'(1);
            end
          end
        end

        // The closing sample's error is folded in via err_sum_d before the compare.
        ST_MEASURE: begin
          if (i_valid) begin
            if (int'(win_cnt_q) == WIN_LEN - 1) begin
              if (err_sum_d < min_err_q) begin
                best_q    <= delay_q;
                min_err_q <= err_sum_d;
              end
`ifdef BER_EARLY_LOCK_EN
              if (err_sum_d == '0) begin
                state_q  <= ST_LOCKED;
                busy_q   <= 1'b0;
                locked_q <= 1'b1;
                fail_q   <= (ERR_THRESH < 0);
              end else begin
                state_q <= ST_NEXT;
              end
`else
              state_q <= ST_NEXT;
`endif
            end else begin
              win_cnt_q <= win_cnt_d;
              err_sum_q <= err_sum_d;
            end
          end
        end

        ST_NEXT: begin
          if (delay_q == LAST_TAP) begin
            state_q  <= ST_LOCKED;
            delay_q  <= best_q;
            busy_q   <= 1'b0;
            locked_q <= 1'b1;
            fail_q   <= (int'(min_err_q) > ERR_THRESH);
          end else begin
            state_q      <= ST_SETTLE;
            delay_q      <= delay_q + DELAY_W'(1);
            settle_cnt_q <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ber_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (start_ok),
    .i_en    (cnt_en),
    .i_inc   (1'b1),
    .o_count (o_bit_count)
  );

  ber_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (start_ok),
    .i_en    (cnt_en),
    .i_inc   (i_err),
    .o_count (o_err_count)
  );

  assign o_delay      = delay_q;
  assign o_busy       = busy_q;
  assign o_locked     = locked_q;
  assign o_fail       = fail_q;
  assign o_best_delay = best_q;
  assign o_min_err    = min_err_q;

endmodule

// File: tb/tb_ber_align_ctrl.sv
// Randomised bench for ber_align_ctrl with a per-tap datapath model and reference results.
module tb_ber_align_ctrl;

  localparam int ND      = 8;
  localparam int DW      = 3;
  localparam int WL      = 16;
  localparam int ST      = 2;
  localparam int CW      = 8;
  localparam int MW      = $clog2(WL + 1);
  localparam int PAT_LEN = ST + WL + 1;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int MIN_ONES = (1 << MW) - 1;

  logic          clock;
  logic          i_reset;
  logic          i_enable;
  logic          i_start;
  logic          i_valid;
  logic          i_err;
  logic [DW-1:0] o_delay;
  logic          o_busy;
  logic          o_locked;
  logic          o_fail;
  logic [DW-1:0] o_best_delay;
  logic [MW-1:0] o_min_err;
  logic [CW-1:0] o_bit_count;
  logic [CW-1:0] o_err_count;

  ber_align_ctrl #(
    .NUM_DELAYS(ND), .DELAY_W(DW), .WIN_LEN(WL),
    .SETTLE(ST), .ERR_THRESH(0), .CNT_W(CW)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_err        (i_err),
    .o_delay      (o_delay),
    .o_busy       (o_busy),
    .o_locked     (o_locked),
    .o_fail       (o_fail),
    .o_best_delay (o_best_delay),
    .o_min_err    (o_min_err),
    .o_bit_count  (o_bit_count),
    .o_err_count  (o_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Datapath model: for each tap, the error bit to return on the k-th valid busy sample.
  bit pat [ND][PAT_LEN];
  int idx [ND];
  int tapErr [ND];
  int busyCycles;
  int refBits;
  int refErrs;
  int expBest;
  int expMin;
  int expBusy;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, let the edge happen, return at the next negedge.
  task automatic applyStimulus(input bit en, input bit vld, input bit st, input int errMode);
    int  tap;
    bit  sweepSample;
    tap         = int'(o_delay);
    sweepSample = o_busy && en && vld;
    i_enable = en;
    i_valid  = vld;
    i_start  = st;
    if (sweepSample && idx[tap] < PAT_LEN) i_err = pat[tap][idx[tap]];
    else if (errMode >= 0)                 i_err = errMode[0];
    else                                   i_err = 1'($urandom_range(0, 1));
    if (o_busy) busyCycles++;
    if (o_locked && en) begin
      if (st) begin
        refBits = 0;
        refErrs = 0;
      end else if (vld) begin
        if (refBits < CNT_MAX) refBits++;
        if (i_err && refErrs < CNT_MAX) refErrs++;
      end
    end
    @(posedge clock);
    if (sweepSample && idx[tap] < PAT_LEN) idx[tap]++;
    @(negedge clock);
  endtask

  task automatic prepSweep();
    bit w [WL];
    for (int t = 0; t < ND; t++) begin
      idx[t] = 0;
      for (int k = 0; k < PAT_LEN; k++) pat[t][k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < WL; k++) w[k] = (k < tapErr[t]);
      for (int k = WL - 1; k > 0; k--) begin
        int j;
        bit tmp;
        j = $urandom_range(0, k);
        tmp = w[k]; w[k] = w[j]; w[j] = tmp;
      end
      for (int k = 0; k < WL; k++) pat[t][ST + k] = w[k];
    end
    busyCycles = 0;
  endtask

  // Best tap is the lowest-numbered tap with the smallest window error count.
  task automatic computeExpected();
    int visited;
    bit early;
    expBest = 0;
    expMin  = MIN_ONES;
    visited = ND;
    early   = 1'b0;
    for (int t = 0; t < ND; t++) begin
      if (tapErr[t] < expMin) begin
        expMin  = tapErr[t];
        expBest = t;
      end
    end
`ifdef BER_EARLY_LOCK_EN
    for (int t = ND - 1; t >= 0; t--) begin
      if (tapErr[t] == 0) begin
        visited = t + 1;
        early   = 1'b1;
      end
    end
`endif
    expBusy = visited * (ST + WL + 1) - (early ? 1 : 0);
  endtask

  task automatic runSweep(input string name, input int validPct, input int enPct,
                          input bit startMid, input bit checkBusy);
    int  n;
    bit  en;
    bit  vld;
    prepSweep();
    computeExpected();
    applyStimulus(1'b1, 1'b1, 1'b1, -1);
    checkOutput({name, "_busy_after_start"}, 64'(o_busy), 64'd1);
    checkOutput({name, "_bits_cleared"}, 64'(o_bit_count), 64'd0);
    checkOutput({name, "_errs_cleared"}, 64'(o_err_count), 64'd0);
    n = 0;
    while (!o_locked && n < 3000) begin
      en  = ($urandom_range(0, 99) < enPct);
      vld = ($urandom_range(0, 99) < validPct);
      applyStimulus(en, vld, startMid && (n == 40), -1);
      n++;
    end
    checkOutput({name, "_lock_timeout"}, 64'(o_locked), 64'd1);
    checkOutput({name, "_busy_end"}, 64'(o_busy), 64'd0);
    checkOutput({name, "_best"}, 64'(o_best_delay), 64'(expBest));
    checkOutput({name, "_delay"}, 64'(o_delay), 64'(expBest));
    checkOutput({name, "_min_err"}, 64'(o_min_err), 64'(expMin));
    checkOutput({name, "_fail"}, 64'(o_fail), 64'(expMin > 0));
    if (checkBusy) checkOutput({name, "_busy_cycles"}, 64'(busyCycles), 64'(expBusy));
  endtask

  initial begin
    int  n;
    int  preBits;
    int  preErrs;
    bit  en;
    bit  vld;
    int  em;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_start  = 1'b0;
    i_valid  = 1'b0;
    i_err    = 1'b0;
    refBits  = 0;
    refErrs  = 0;
    busyCycles = 0;
    for (int t = 0; t < ND; t++) idx[t] = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    i_reset = 1'b0;

    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, -1);
    checkOutput("rst_delay", 64'(o_delay), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_locked", 64'(o_locked), 64'd0);
    checkOutput("rst_fail", 64'(o_fail), 64'd0);
    checkOutput("rst_best", 64'(o_best_delay), 64'd0);
    checkOutput("rst_min_err", 64'(o_min_err), 64'(MIN_ONES));
    checkOutput("rst_bits", 64'(o_bit_count), 64'd0);
    checkOutput("rst_errs", 64'(o_err_count), 64'd0);

    // Only tap 5 is clean; a start pulse mid-sweep must not restart anything.
    for (int t = 0; t < ND; t++) tapErr[t] = WL;
    tapErr[5] = 0;
    runSweep("tap5", 100, 100, 1'b1, 1'b1);

    // Locked accumulation with gaps in i_valid and a 10-cycle enable drop.
    n = 0;
    preBits = 0;
    preErrs = 0;
    while (refBits < 100 && n < 2000) begin
      en  = !(n >= 30 && n < 40);
      vld = en ? ($urandom_range(0, 1) == 1) : 1'b1;
      em  = (en && vld) ? int'(refBits == 7 || refBits == 33 || refBits == 61 || refBits == 90) : 1;
      if (n == 30) begin
        preBits = int'(o_bit_count);
        preErrs = int'(o_err_count);
      end
      if (n == 40) begin
        checkOutput("frozen_bits", 64'(o_bit_count), 64'(preBits));
        checkOutput("frozen_errs", 64'(o_err_count), 64'(preErrs));
        checkOutput("frozen_locked", 64'(o_locked), 64'd1);
      end
      applyStimulus(en, vld, !en, em);
      n++;
    end
    checkOutput("lock_bits", 64'(o_bit_count), 64'd100);
    checkOutput("lock_errs", 64'(o_err_count), 64'd4);
    checkOutput("lock_delay", 64'(o_delay), 64'd5);

    repeat (300) applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("sat_bits", 64'(o_bit_count), 64'(CNT_MAX));
    checkOutput("sat_errs", 64'(o_err_count), 64'(CNT_MAX));
    checkOutput("sat_model_errs", 64'(o_err_count), 64'(refErrs));

    // Tie between taps 2 and 6; restart from LOCKED clears the counters.
    for (int t = 0; t < ND; t++) tapErr[t] = 10;
    tapErr[2] = 3;
    tapErr[6] = 3;
    runSweep("tie", 100, 100, 1'b0, 1'b1);

    // Clean tap 1: early lock shortens the sweep, otherwise full sweep lands on tap 1.
    for (int t = 0; t < ND; t++) tapErr[t] = $urandom_range(1, WL);
    tapErr[1] = 0;
    runSweep("tap1", 100, 100, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < ND; t++) tapErr[t] = $urandom_range((r < 2) ? 1 : 0, WL);
      runSweep($sformatf("rand%0d", r), 70, 90, 1'b1, 1'b0);
    end

    // Reset mid-MEASURE at tap 3 with i_enable low.
    for (int t = 0; t < ND; t++) tapErr[t] = 5;
    tapErr[1] = 2;
    prepSweep();
    applyStimulus(1'b1, 1'b1, 1'b1, -1);
    n = 0;
    while (!(int'(o_delay) == 3 && idx[3] == ST + 5) && n < 500) begin
      applyStimulus(1'b1, 1'b1, 1'b0, -1);
      n++;
    end
    checkOutput("mid_reach_tap3", 64'(n < 500), 64'd1);
    checkOutput("mid_best_before", 64'(o_best_delay), 64'd1);
    i_reset  = 1'b1;
    i_enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("mid_rst_delay", 64'(o_delay), 64'd0);
    checkOutput("mid_rst_busy", 64'(o_busy), 64'd0);
    checkOutput("mid_rst_locked", 64'(o_locked), 64'd0);
    checkOutput("mid_rst_fail", 64'(o_fail), 64'd0);
    checkOutput("mid_rst_best", 64'(o_best_delay), 64'd0);
    checkOutput("mid_rst_min", 64'(o_min_err), 64'(MIN_ONES));
    checkOutput("mid_rst_bits", 64'(o_bit_count), 64'd0);
    i_reset = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, -1);
    checkOutput("post_rst_idle", 64'(o_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
